// File: rtl/ring_rd_sched.sv
// Ring read scheduler: for each queued L1A, loads the ring read address and
// streams WORDS_PER_SMP x smp_lim words, stalling on ring-almost-empty or downstream almost-full.
module ring_rd_sched #(
    parameter int WORDS_PER_SMP = 96,
    parameter int EVT_CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST_RESYNC,
    input  logic [6:0]           SAMP_MAX,
    input  logic                 L1A_BUF_MT,
    input  logic                 EVT_BUF_AFL,
    input  logic                 RING_AMT,
    output logic                 LD_ADDR,
    output logic                 NXT_L1A,
    output logic                 RD,
    output logic [6:0]           SMP,
    output logic [6:0]           SEQ,
    output logic [2:0]           EVT_STATE,
    output logic                 EVT_DONE,
    output logic [EVT_CNT_W-1:0] EVT_CNT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [6:0] SEQ_LAST = 7'(WORDS_PER_SMP - 1);

    state_t               state_q;
    logic                 afl_meta_q;
    logic                 afl_s_q;
    logic [6:0]           smp_q;
    logic [6:0]           seq_q;
    logic [6:0]           smp_lim_q;
    logic [EVT_CNT_W-1:0] evt_cnt_q;
    logic                 ld_addr_q;
    logic                 evt_done_q;

    logic ring_ok;
    logic seq_last;
    logic smp_last;

    // EVT_BUF_AFL comes from another clock domain; only afl_s_q may steer the FSM.
    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            afl_meta_q <= 1'b0;
            afl_s_q    <= 1'b0;
        end else begin
            afl_meta_q <= EVT_BUF_AFL;
            afl_s_q    <= afl_meta_q;
        end
    end

    assign ring_ok  = !RING_AMT && !afl_s_q;
    assign seq_last = (seq_q == SEQ_LAST);
    assign smp_last = (smp_q == smp_lim_q - 7'd1);

    always_ff @(posedge CLK or posedge RST_RESYNC) begin
        if (RST_RESYNC) begin
            state_q    <= S_IDLE;
            smp_q      <= 7'd0;
            seq_q      <= 7'd0;
            smp_lim_q  <= 7'd1;
            evt_cnt_q  <= '0;
            ld_addr_q  <= 1'b0;
            evt_done_q <= 1'b0;
        end else begin
            ld_addr_q  <= 1'b0;
            evt_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!L1A_BUF_MT && !afl_s_q) begin
                        state_q   <= S_LOAD;
                        ld_addr_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A zero sample count still reads one full sample.
                    smp_lim_q <= (SAMP_MAX == 7'd0) ? 7'd1 : SAMP_MAX;
                    smp_q     <= 7'd0;
                    seq_q     <= 7'd0;
                    state_q   <= S_READ;
                end
                S_READ: begin
                    if (!ring_ok) begin
                        state_q <= S_PAUSE;
                    end else if (!seq_last) begin
                        seq_q <= seq_q + 7'd1;
                    end else if (smp_last) begin
                        state_q    <= S_DONE;
                        evt_done_q <= 1'b1;
                    end else begin
                        seq_q <= 7'd0;
                        smp_q <= smp_q + 7'd1;
                    end
                end
                S_PAUSE: begin
                    if (ring_ok) begin
                        state_q <= S_READ;
                    end
                end
                S_DONE: begin
                    evt_cnt_q <= evt_cnt_q + 1'b1;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // RD is a same-cycle strobe: the ring consumes one word on every rising
    // edge where RD=1; there is no back-pressure on it beyond RING_AMT/afl_s.
    assign RD        = (state_q == S_READ) && ring_ok;
    assign LD_ADDR   = ld_addr_q;
    assign NXT_L1A   = ld_addr_q;
    assign EVT_DONE  = evt_done_q;
    assign SMP       = smp_q;
    assign SEQ       = seq_q;
    assign EVT_STATE = state_q;
    assign EVT_CNT   = evt_cnt_q;

endmodule
